// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one rdy-handshaked unified memory between the
// I-cache fill path and the D-cache miss/writeback path, one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              err
);

    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, last_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TMO_W-1:0]  tmo;
    logic              grant_any;
    logic              grant_d;
    logic              tmo_hit;

    // On a tie the requester that did not win last time gets the grant.
    assign grant_any = i_req | d_req;
    assign grant_d   = d_req & (~i_req | (last_gnt == OWN_I));
    assign tmo_hit   = (tmo == TMO_W'(TMO_CYC - 1));

    // NOTE: every signal assigned in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_rdy || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_I;
            last_gnt <= OWN_I;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            tmo      <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            if (state == WAIT) tmo <= tmo + 1'b1;
            else               tmo <= '0;

            if (state == IDLE && grant_any) begin
                owner    <= grant_d ? OWN_D : OWN_I;
                last_gnt <= grant_d ? OWN_D : OWN_I;
                addr_q   <= grant_d ? d_addr : i_addr;
                we_q     <= grant_d & d_we;
                wdata_q  <= grant_d ? d_wdata : '0;
            end

            // Writes leave the owner's read line untouched; a timeout zeroes it.
            if (state == WAIT) begin
                if (mem_rdy) begin
                    if (!we_q) begin
                        if (owner == OWN_D) d_rdata <= mem_rdata;
                        else                i_rdata <= mem_rdata;
                    end
                end else if (tmo_hit) begin
                    err <= 1'b1;
                    if (owner == OWN_D) d_rdata <= '0;
                    else                i_rdata <= '0;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = (state == ISSUE) & ~we_q;
    assign mem_we    = (state == ISSUE) & we_q;
    assign i_done    = (state == RESP) & (owner == OWN_I);
    assign d_done    = (state == RESP) & (owner == OWN_D);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin, writes, timeout,
// asynchronous reset mid-transaction and stray mem_rdy outside WAIT.
module tb_mem_arbiter;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 64;
    localparam int TMO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;
    logic              busy;
    logic              err;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle: raise mem_rdy n cycles after the strobe, end in RESP.
    task automatic serve(input int n, input logic [63:0] data);
        repeat (n) tick();
        mem_rdy   = 1'b1;
        mem_rdata = data;
        tick();
        mem_rdy   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [63:0] rd_data [3];
    logic [13:0] exp_addr[3];
    logic        exp_d   [3];

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_rdy = 1'b0;
        apply_reset();

        check("rst_busy",   busy,   0);
        check("rst_err",    err,    0);
        check("rst_mem_re", mem_re, 0);
        check("rst_maddr",  mem_addr, 0);
        check("rst_drdata", d_rdata, 0);

        // 1: single D read, rdy 4 cycles after strobe -> done in cycle 6
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0010;
        tick();                                            // cycle 1
        check("t1_mem_re",  mem_re,   1);
        check("t1_mem_we",  mem_we,   0);
        check("t1_maddr",   mem_addr, 14'h0010);
        tick();                                            // cycle 2
        check("t1_re_once", mem_re,   0);
        check("t1_maddr_hold", mem_addr, 14'h0010);
        serve(3, 64'hAAAA_AAAA_AAAA_AAAA);                 // rdy in cycle 5, now cycle 6
        check("t1_d_done",  d_done,  1);
        check("t1_d_rdata", d_rdata, 64'hAAAA_AAAA_AAAA_AAAA);
        check("t1_i_done",  i_done,  0);
        d_req = 1'b0;
        tick();                                            // cycle 7
        check("t1_done_once", d_done, 0);
        check("t1_idle",      busy,   0);

        // 2: simultaneous held requests from reset alternate D, I, D
        apply_reset();
        i_req = 1'b1; i_addr = 14'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0200;
        rd_data[0] = 64'h1111_0000_0000_0001; exp_addr[0] = 14'h0200; exp_d[0] = 1'b1;
        rd_data[1] = 64'h2222_0000_0000_0002; exp_addr[1] = 14'h0100; exp_d[1] = 1'b0;
        rd_data[2] = 64'h3333_0000_0000_0003; exp_addr[2] = 14'h0200; exp_d[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t2_maddr%0d", k), mem_addr, exp_addr[k]);
            check($sformatf("t2_re%0d", k),    mem_re,   1);
            serve(2, rd_data[k]);
            check($sformatf("t2_ddone%0d", k), d_done, exp_d[k]);
            check($sformatf("t2_idone%0d", k), i_done, !exp_d[k]);
            if (exp_d[k]) check($sformatf("t2_drd%0d", k), d_rdata, rd_data[k]);
            else          check($sformatf("t2_ird%0d", k), i_rdata, rd_data[k]);
            if (k == 2) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
            check($sformatf("t2_bubble%0d", k), busy, 0);
            check($sformatf("t2_nodone%0d", k), d_done | i_done, 0);
        end

        // 3: D write leaves d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0055; d_wdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        check("t3_mem_we",  mem_we,    1);
        check("t3_mem_re",  mem_re,    0);
        check("t3_wdata",   mem_wdata, 64'h1234_5678_9ABC_DEF0);
        serve(1, 64'hDEAD_BEEF_DEAD_BEEF);
        check("t3_d_done",  d_done,  1);
        check("t3_d_rdata", d_rdata, 64'h3333_0000_0000_0003);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // 4: timeout after 16 WAIT cycles, then err stays sticky
        i_req = 1'b1; i_addr = 14'h0077;
        tick();                                            // ISSUE
        repeat (TMO_CYC) tick();                           // last WAIT cycle
        check("t4_err_pre",  err,    0);
        check("t4_busy_pre", i_done, 0);
        tick();                                            // RESP
        check("t4_err",     err,     1);
        check("t4_i_done",  i_done,  1);
        check("t4_i_rdata", i_rdata, 0);
        i_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0099;
        tick();
        serve(1, 64'h5555_5555_5555_5555);
        check("t4_good_done",  d_done,  1);
        check("t4_good_rdata", d_rdata, 64'h5555_5555_5555_5555);
        check("t4_err_sticky", err,     1);
        d_req = 1'b0;
        tick();

        // 6: mem_rdy high in IDLE and ISSUE is ignored
        mem_rdy = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        d_req = 1'b1; d_addr = 14'h0042;
        tick();                                            // ISSUE, rdy still high
        check("t6_issue_re", mem_re, 1);
        tick();                                            // first WAIT cycle
        mem_rdy = 1'b0; mem_rdata = '0;
        check("t6_no_done_w", d_done, 0);
        tick();
        check("t6_still_busy", busy,   1);
        check("t6_no_done",    d_done, 0);
        serve(1, 64'h0123_4567_89AB_CDEF);
        check("t6_done",  d_done,  1);
        check("t6_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        d_req = 1'b0;
        tick();

        // 5: asynchronous reset during WAIT abandons the transaction
        i_req = 1'b1; i_addr = 14'h003C;
        tick();
        tick();
        tick();
        check("t5_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_busy",   busy,     0);
        check("t5_err",    err,      0);
        check("t5_maddr",  mem_addr, 0);
        check("t5_drdata", d_rdata,  0);
        check("t5_done",   i_done | d_done, 0);
        tick();
        rst_n = 1'b1;
        check("t5_idle", busy, 0);
        tick();
        check("t5_re",    mem_re,   1);
        check("t5_maddr2", mem_addr, 14'h003C);
        serve(2, 64'h7777_8888_9999_AAAA);
        check("t5_i_done",  i_done,  1);
        check("t5_i_rdata", i_rdata, 64'h7777_8888_9999_AAAA);
        check("t5_d_done",  d_done,  0);
        i_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
